// File: rtl/mc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mc_sequencer
// Description : Multi-cycle RV32 control sequencer; steps fetch/decode/execute
//               phases and drives datapath strobes from state and IR opcode.
// Revision    : 1.0 - initial release
// ============================================================================
module mc_sequencer (
    input  logic        clock,
    input  logic        resetn,
    input  logic        run,
    input  logic [31:0] DIN,
    input  logic        br_taken,
    output logic [31:0] IR,
    output logic [2:0]  state,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        ADDR_sel,
    output logic        W,
    output logic        alu_src,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        done,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_FWAIT  = 3'd2,
        S_DECODE = 3'd3,
        S_EXEC   = 3'd4,
        S_MEM    = 3'd5,
        S_MWAIT  = 3'd6,
        S_WB     = 3'd7
    } state_t;

    localparam logic [6:0] C_OP_R    = 7'b0110011;
    localparam logic [6:0] C_OP_I    = 7'b0010011;
    localparam logic [6:0] C_OP_LD   = 7'b0000011;
    localparam logic [6:0] C_OP_ST   = 7'b0100011;
    localparam logic [6:0] C_OP_BR   = 7'b1100011;
    localparam logic [6:0] C_OP_JAL  = 7'b1101111;
    localparam logic [6:0] C_OP_JALR = 7'b1100111;
    localparam logic [6:0] C_OP_LUI  = 7'b0110111;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_ir;
    logic        r_illegal;

    logic [6:0]  w_op;
    logic        w_is_r, w_is_i, w_is_ld, w_is_st, w_is_br;
    logic        w_is_jal, w_is_jalr, w_is_lui, w_supported, w_rd_nz;
    logic        w_set_ill, w_clr_ill, w_retire;

    assign w_op        = r_ir[6:0];
    assign w_is_r      = (w_op == C_OP_R);
    assign w_is_i      = (w_op == C_OP_I);
    assign w_is_ld     = (w_op == C_OP_LD);
    assign w_is_st     = (w_op == C_OP_ST);
    assign w_is_br     = (w_op == C_OP_BR);
    assign w_is_jal    = (w_op == C_OP_JAL);
    assign w_is_jalr   = (w_op == C_OP_JALR);
    assign w_is_lui    = (w_op == C_OP_LUI);
    assign w_supported = w_is_r | w_is_i | w_is_ld | w_is_st | w_is_br |
                         w_is_jal | w_is_jalr | w_is_lui;
    assign w_rd_nz     = (r_ir[11:7] != 5'd0);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_ir      <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next;
            if (ir_load) begin
                r_ir <= DIN;
            end
            if (w_clr_ill) begin
                r_illegal <= 1'b0;
            end else if (w_set_ill) begin
                r_illegal <= 1'b1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        ir_load   = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        ADDR_sel  = 1'b0;
        W         = 1'b0;
        alu_src   = 1'b0;
        rf_we     = 1'b0;
        wb_sel    = 2'b00;
        done      = 1'b0;
        w_set_ill = 1'b0;
        w_clr_ill = 1'b0;
        w_retire  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_next    = S_FETCH;
                    w_clr_ill = 1'b1;
                end
            end
            S_FETCH: begin
                w_next = S_FWAIT;
            end
            S_FWAIT: begin
                ir_load = 1'b1;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                if (w_supported) begin
                    w_next = S_EXEC;
                end else begin
                    w_next    = S_IDLE;
                    w_set_ill = 1'b1;
                end
            end
            S_EXEC: begin
                alu_src = w_is_i | w_is_ld | w_is_st | w_is_jalr;
                if (w_is_br) begin
                    w_retire = 1'b1;
                    pc_load  = br_taken;
                    pc_inc   = ~br_taken;
                end else if (w_is_ld | w_is_st) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                ADDR_sel = 1'b1;
                alu_src  = 1'b1;
                if (w_is_st) begin
                    W        = 1'b1;
                    pc_inc   = 1'b1;
                    w_retire = 1'b1;
                end else begin
                    w_next = S_MWAIT;
                end
            end
            S_MWAIT: begin
                ADDR_sel = 1'b1;
                w_next   = S_WB;
            end
            S_WB: begin
                rf_we = w_rd_nz;
                if (w_is_ld) begin
                    wb_sel = 2'b01;
                end else if (w_is_jal | w_is_jalr) begin
                    wb_sel = 2'b10;
                end else if (w_is_lui) begin
                    wb_sel = 2'b11;
                end
                if (w_is_jal | w_is_jalr) begin
                    pc_load = 1'b1;
                end else begin
                    pc_inc = 1'b1;
                end
                w_retire = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // Every retire point samples run to decide between back-to-back fetch and idling.
        if (w_retire) begin
            done   = 1'b1;
            w_next = run ? S_FETCH : S_IDLE;
        end
    end

    assign state   = r_state;
    assign IR      = r_ir;
    assign illegal = r_illegal;

endmodule
`default_nettype wire
